// File: rtl/mkgauss_rand_src.sv
// Random-word source for the MKGAUSS r1/r2 inputs: fetches 64-bit PRNG words in pairs,
// issues them as single-cycle pulses and throttles on outstanding val_valid returns.
module mkgauss_rand_src #(
  parameter int unsigned CNT_W           = 12,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] sample_num,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             prng_valid,
  input  logic [63:0]      prng_data,
  output logic             prng_ready,
  output logic             r1_valid,
  output logic [63:0]      r1,
  output logic             r2_valid,
  output logic [63:0]      r2,
  input  logic             val_valid,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam int unsigned OUT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    FETCH2,
    ISSUE1,
    ISSUE2,
    DRAIN
  } state_t;

  state_t           state;
  logic [63:0]      w1;
  logic [63:0]      w2;
  logic [OUT_W-1:0] outstanding;
  logic [CNT_W-1:0] target;

  logic prng_xfer_c;
  logic out_inc_c;
  logic out_dec_c;
  logic room_c;

  // prng_ready is a registered copy of "in a FETCH state", so this is the real handshake
  assign prng_xfer_c = prng_valid && prng_ready;
  assign out_inc_c   = (state == ISSUE2);
  assign out_dec_c   = val_valid && (outstanding != '0);
  assign room_c      = (outstanding < OUT_W'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      w1          <= '0;
      w2          <= '0;
      outstanding <= '0;
      target      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      prng_ready  <= 1'b0;
      r1_valid    <= 1'b0;
      r1          <= '0;
      r2_valid    <= 1'b0;
      r2          <= '0;
      issued_cnt  <= '0;
    end else begin
      r1_valid <= 1'b0;
      r1       <= '0;
      r2_valid <= 1'b0;
      r2       <= '0;
      done     <= 1'b0;

      // Simultaneous issue and return cancel out; a return with nothing in flight is an error
      if (out_inc_c && !out_dec_c) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (!out_inc_c && out_dec_c) begin
        outstanding <= outstanding - OUT_W'(1);
      end
      if (val_valid && (outstanding == '0)) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            target     <= sample_num;
            issued_cnt <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            if (sample_num == '0) begin
              state <= DRAIN;
            end else begin
              state      <= FETCH1;
              prng_ready <= 1'b1;
            end
          end
        end
        FETCH1: begin
          if (prng_xfer_c) begin
            w1    <= prng_data;
            state <= FETCH2;
          end
        end
        FETCH2: begin
          if (prng_xfer_c) begin
            w2         <= prng_data;
            prng_ready <= 1'b0;
            state      <= ISSUE1;
          end
        end
        ISSUE1: begin
          if (room_c) begin
            r1_valid <= 1'b1;
            r1       <= w1;
            state    <= ISSUE2;
          end
        end
        ISSUE2: begin
          r2_valid   <= 1'b1;
          r2         <= w2;
          issued_cnt <= issued_cnt + CNT_W'(1);
          if ((issued_cnt + CNT_W'(1)) == target) begin
            state <= DRAIN;
          end else begin
            state      <= FETCH1;
            prng_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
